// File: rtl/oam_dma.sv
// Sprite DMA engine for CPU register $4014.
// A CPU write of page P to TRIGGER_ADDR stalls the CPU and copies
// $PP00..$PP(XFER_LEN-1) to OAM_DATA_ADDR as one read cycle followed by one
// write cycle per byte, so the PPU's OAM address auto-increments.
// Optional feature: define OAM_DMA_DMC_STALL_EN to add a dmc_stall input.
// While it is high at the edge ending a READ cycle, that read is discarded
// and the same address is read again.
module oam_dma #(
    parameter logic [15:0] TRIGGER_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int unsigned XFER_LEN      = 256
) (
    input  logic        cpu_clk,
    input  logic        reset,
    input  logic [15:0] bus_addr,
    input  logic [7:0]  bus_din,
    input  logic        bus_wr,
    input  logic        odd_or_even,
    input  logic [7:0]  mem_rdata,
`ifdef OAM_DMA_DMC_STALL_EN
    input  logic        dmc_stall,
`endif
    output logic        dma_hijack,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_dout,
    output logic        dma_wr,
    output logic        busy
);

    localparam int unsigned IDX_W  = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 16;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(XFER_LEN - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t              state, state_nx;
    logic [IDX_W-1:0]    page, page_nx;
    logic [IDX_W-1:0]    idx, idx_nx;
    logic [DATA_W-1:0]   latch, latch_nx;

    logic                hijack_nx;
    logic [ADDR_W-1:0]   addr_nx;
    logic [DATA_W-1:0]   dout_nx;
    logic                wr_nx;
    logic                read_hold;

`ifdef OAM_DMA_DMC_STALL_EN
    assign read_hold = dmc_stall;
`else
    assign read_hold = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge cpu_clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            page  <= '0;
            idx   <= '0;
            latch <= '0;
        end else begin
            state <= state_nx;
            page  <= page_nx;
            idx   <= idx_nx;
            latch <= latch_nx;
        end
    end

    // Next-state, datapath updates and the bus values for the next cycle
    always_comb begin
        state_nx  = state;
        page_nx   = page;
        idx_nx    = idx;
        latch_nx  = latch;
        hijack_nx = 1'b0;
        addr_nx   = '0;
        dout_nx   = '0;
        wr_nx     = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus_wr && (bus_addr == TRIGGER_ADDR)) begin
                    page_nx  = bus_din;
                    idx_nx   = '0;
                    state_nx = HALT;
                end
            end
            HALT: begin
                state_nx = odd_or_even ? ALIGN : READ;
            end
            ALIGN: begin
                state_nx = READ;
            end
            READ: begin
                if (!read_hold) begin
                    latch_nx = mem_rdata;
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                if (idx == LAST_IDX) begin
                    state_nx = IDLE;
                end else begin
                    idx_nx   = idx + IDX_W'(1);
                    state_nx = READ;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Outputs follow the state being entered so they register in step with it
        hijack_nx = (state_nx != IDLE);
        if (state_nx == READ) begin
            addr_nx = {page_nx, idx_nx};
        end else if (state_nx == WRITE) begin
            addr_nx = OAM_DATA_ADDR;
            dout_nx = latch_nx;
            wr_nx   = 1'b1;
        end
    end

    // Registered bus outputs
    always_ff @(posedge cpu_clk or negedge reset) begin
        if (!reset) begin
            dma_hijack <= 1'b0;
            busy       <= 1'b0;
            dma_addr   <= '0;
            dma_dout   <= '0;
            dma_wr     <= 1'b0;
        end else begin
            dma_hijack <= hijack_nx;
            busy       <= hijack_nx;
            dma_addr   <= addr_nx;
            dma_dout   <= dout_nx;
            dma_wr     <= wr_nx;
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: even/odd parity transfers, ignored re-trigger,
// page $FF wrap, asynchronous abort and, with OAM_DMA_DMC_STALL_EN, DMC stalls.
module tb_oam_dma;

    logic        cpu_clk = 1'b0;
    logic        reset;
    logic [15:0] bus_addr;
    logic [7:0]  bus_din;
    logic        bus_wr;
    logic        odd_or_even;
    logic [7:0]  mem_rdata;
    logic        stall;
    logic        dma_hijack;
    logic [15:0] dma_addr;
    logic [7:0]  dma_dout;
    logic        dma_wr;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    // Recorded activity of the most recent transfer
    int          wcnt, rcnt, hcnt, bad_waddr, hold_reads;
    logic [7:0]  wdata [1024];
    logic [15:0] raddr [1024];

    always #5 cpu_clk = ~cpu_clk;

    // Bench memory: page $02 holds i^5A; other pages are offset by (page-2)
    function automatic logic [7:0] mem_f(input logic [15:0] a);
        logic [7:0] hi;
        hi = a[15:8] - 8'h02;
        return a[7:0] ^ 8'h5A ^ hi;
    endfunction

    assign mem_rdata = mem_f(dma_addr) ^ (stall ? 8'hFF : 8'h00);

    oam_dma dut (
        .cpu_clk     (cpu_clk),
        .reset       (reset),
        .bus_addr    (bus_addr),
        .bus_din     (bus_din),
        .bus_wr      (bus_wr),
        .odd_or_even (odd_or_even),
        .mem_rdata   (mem_rdata),
`ifdef OAM_DMA_DMC_STALL_EN
        .dmc_stall   (stall),
`endif
        .dma_hijack  (dma_hijack),
        .dma_addr    (dma_addr),
        .dma_dout    (dma_dout),
        .dma_wr      (dma_wr),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_hijack"}, 32'(dma_hijack), 32'h0);
        check({tag, "_busy"},   32'(busy),       32'h0);
        check({tag, "_wr"},     32'(dma_wr),     32'h0);
        check({tag, "_addr"},   32'(dma_addr),   32'h0);
        check({tag, "_dout"},   32'(dma_dout),   32'h0);
    endtask

    // Trigger a transfer of page pg and record it until busy drops.
    // inject>=0: write page $07 to $4014 on that cycle; abort_w>=0: assert
    // reset just after that many writes; stall_idx>=0: stall its read 3 cycles.
    task automatic run(input logic [7:0] pg, input logic par, input int inject,
                       input int abort_w, input int stall_idx);
        int  stall_left;
        bit  stall_done;
        bit  done;
        wcnt = 0; rcnt = 0; hcnt = 0; bad_waddr = 0; hold_reads = 0;
        stall_left = 0; stall_done = 0; done = 0;
        @(negedge cpu_clk);
        bus_addr = 16'h4014; bus_din = pg; bus_wr = 1'b1; odd_or_even = 1'b0;
        for (int n = 0; n < 1200; n++) begin
            @(negedge cpu_clk);
            if (dma_hijack) hcnt++;
            if (dma_wr) begin
                if (dma_addr != 16'h2004) bad_waddr++;
                wdata[wcnt] = dma_dout;
                wcnt++;
            end else if (dma_hijack && dma_addr != 16'h0000) begin
                raddr[rcnt] = dma_addr;
                rcnt++;
                if (stall_idx >= 0 && dma_addr == {pg, 8'(stall_idx)}) hold_reads++;
            end
            if (n == 0) begin
                bus_wr = 1'b0; bus_addr = 16'h0000; odd_or_even = par;
            end
            if (n == inject) begin
                bus_addr = 16'h4014; bus_din = 8'h07; bus_wr = 1'b1;
            end else if (n == inject + 1) begin
                bus_addr = 16'h0000; bus_wr = 1'b0;
            end
            if (stall) begin
                stall_left--;
                if (stall_left == 0) stall = 1'b0;
            end else if (!stall_done && stall_idx >= 0 && !dma_wr
                         && dma_addr == {pg, 8'(stall_idx)}) begin
                stall = 1'b1; stall_left = 3; stall_done = 1;
            end
            if (abort_w >= 0 && dma_wr && wcnt == abort_w) begin
                #2 reset = 1'b0;
                #1 check_idle_outputs("abort_now");
                repeat (3) begin
                    @(negedge cpu_clk);
                    check("abort_hold_hijack", 32'(dma_hijack), 32'h0);
                    check("abort_hold_wr", 32'(dma_wr), 32'h0);
                end
                reset = 1'b1;
                @(negedge cpu_clk);
                check("abort_rel_busy", 32'(busy), 32'h0);
                done = 1;
                break;
            end
            if (n > 0 && !busy) begin
                done = 1;
                break;
            end
        end
        check("run_terminates", 32'(done), 32'h1);
    endtask

    initial begin
        reset = 1'b0; bus_addr = '0; bus_din = '0; bus_wr = 1'b0;
        odd_or_even = 1'b0; stall = 1'b0;
        repeat (3) @(negedge cpu_clk);
        check_idle_outputs("reset");
        reset = 1'b1;
        @(negedge cpu_clk);
        check_idle_outputs("post_reset");

        // A write to another address must not start anything
        bus_addr = 16'h4015; bus_din = 8'h02; bus_wr = 1'b1;
        @(negedge cpu_clk);
        bus_wr = 1'b0;
        @(negedge cpu_clk);
        check("other_addr_busy", 32'(busy), 32'h0);

        // Even parity, page $02
        run(8'h02, 1'b0, -1, -1, -1);
        check("even_hijack_cycles", 32'(hcnt), 32'd513);
        check("even_writes", 32'(wcnt), 32'd256);
        check("even_reads", 32'(rcnt), 32'd256);
        check("even_bad_waddr", 32'(bad_waddr), 32'd0);
        for (int i = 0; i < 256; i++) begin
            check("even_data", 32'(wdata[i]), 32'(8'(i) ^ 8'h5A));
            check("even_raddr", 32'(raddr[i]), 32'h0200 + 32'(i));
        end
        check_idle_outputs("even_end");

        // Odd parity adds one ALIGN cycle
        run(8'h02, 1'b1, -1, -1, -1);
        check("odd_hijack_cycles", 32'(hcnt), 32'd514);
        check("odd_writes", 32'(wcnt), 32'd256);
        check("odd_reads", 32'(rcnt), 32'd256);
        for (int i = 0; i < 256; i++)
            check("odd_data", 32'(wdata[i]), 32'(8'(i) ^ 8'h5A));

        // Re-trigger to page $07 at cycle 100 is ignored
        run(8'h02, 1'b0, 100, -1, -1);
        check("retrig_hijack_cycles", 32'(hcnt), 32'd513);
        check("retrig_writes", 32'(wcnt), 32'd256);
        for (int i = 0; i < 256; i++)
            check("retrig_raddr", 32'(raddr[i]), 32'h0200 + 32'(i));

        // Page $FF wraps idx without carrying
        run(8'hFF, 1'b0, -1, -1, -1);
        check("ff_writes", 32'(wcnt), 32'd256);
        check("ff_last_raddr", 32'(raddr[255]), 32'hFFFF);
        check("ff_first_raddr", 32'(raddr[0]), 32'hFF00);
        check("ff_bad_waddr", 32'(bad_waddr), 32'd0);
        check("ff_data0", 32'(wdata[0]), 32'hA7);
        check("ff_data255", 32'(wdata[255]), 32'h58);
        repeat (2) @(negedge cpu_clk);
        check("ff_busy_after", 32'(busy), 32'h0);
        check("ff_wr_after", 32'(dma_wr), 32'h0);

        // Asynchronous reset at write #37, then a clean restart
        run(8'h02, 1'b0, -1, 37, -1);
        check("abort_writes", 32'(wcnt), 32'd37);
        run(8'h02, 1'b0, -1, -1, -1);
        check("restart_hijack_cycles", 32'(hcnt), 32'd513);
        check("restart_writes", 32'(wcnt), 32'd256);
        check("restart_raddr0", 32'(raddr[0]), 32'h0200);
        check("restart_data0", 32'(wdata[0]), 32'h5A);
        check("restart_data255", 32'(wdata[255]), 32'hA5);

`ifdef OAM_DMA_DMC_STALL_EN
        // Three stalled cycles on the read of idx 10
        run(8'h02, 1'b0, -1, -1, 10);
        check("stall_hijack_cycles", 32'(hcnt), 32'd516);
        check("stall_writes", 32'(wcnt), 32'd256);
        check("stall_hold_reads", 32'(hold_reads), 32'd4);
        check("stall_data10", 32'(wdata[10]), 32'h50);
        check("stall_data11", 32'(wdata[11]), 32'h51);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
